// File: rtl/popcount_scale_acc.sv
// Scaled popcount accumulator. Words arrive over valid/ready and are split into chunks, LSB first.
// Each chunk's popcount<<SCALE_SH is summed with saturation until in_last closes the block.
//
// state | meaning
// IDLE  | ready for a word; acc kept between words of the same block
// LOOK  | one chunk addressed per cycle; previous table output added to acc
// DRAIN | final table output added; emit result if the word was last
// OUT   | result held on out_data until out_ready
module popcount_scale_acc #(
  parameter int DATA_W   = 16,
  parameter int CHUNK_W  = 4,
  parameter int SCALE_SH = 5,
  parameter int OUT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data
);

  localparam int NCHUNK = DATA_W / CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOOK, S_DRAIN, S_OUT} state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  word_q;
  logic               last_q;
  logic [IDX_W-1:0]   idx;
  logic [OUT_W-1:0]   acc;
  logic [OUT_W-1:0]   lut_q;
  logic               fresh;
  logic               accept;
  logic [DATA_W-1:0]  word_sh;
  logic [CHUNK_W-1:0] chunk;
  logic [OUT_W:0]     sum_wide;
  logic [OUT_W-1:0]   sum_sat;

  function automatic logic [OUT_W-1:0] pc_scaled(input logic [CHUNK_W-1:0] c);
    logic [OUT_W-1:0] n;
    n = '0;
    for (int i = 0; i < CHUNK_W; i++) n = n + OUT_W'(c[i]);
    return n << SCALE_SH;
  endfunction

  assign word_sh  = word_q >> (32'(idx) * CHUNK_W);
  assign chunk    = word_sh[CHUNK_W-1:0];
  assign sum_wide = {1'b0, acc} + {1'b0, lut_q};
  assign sum_sat  = sum_wide[OUT_W] ? {OUT_W{1'b1}} : sum_wide[OUT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_nxt = S_LOOK;
      end
      S_LOOK:  if (idx == IDX_LAST) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = last_q ? S_OUT : S_IDLE;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q   <= '0;
      last_q   <= 1'b0;
      idx      <= '0;
      acc      <= '0;
      lut_q    <= '0;
      fresh    <= 1'b1;
      out_data <= '0;
    end else begin
      if (accept) begin
        word_q <= in_data;
        last_q <= in_last;
        idx    <= '0;
        if (fresh) begin
          acc   <= '0;
          fresh <= 1'b0;
        end
      end
      if (state == S_LOOK) begin
        lut_q <= pc_scaled(chunk);
        idx   <= idx + 1'b1;
        // first LOOK cycle: lut_q still holds the previous word's last entry
        if (idx != '0) acc <= sum_sat;
      end
      if (state == S_DRAIN) begin
        acc <= sum_sat;
        if (last_q) out_data <= sum_sat;
      end
      if (state == S_OUT && out_ready) fresh <= 1'b1;
    end
  end

endmodule

// File: tb/tb_popcount_scale_acc.sv
// Directed bench for popcount_scale_acc: latency, block accumulation, saturation,
// back-pressure and mid-operation reset, with hand-computed expected sums.
module tb_popcount_scale_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  int checks = 0;
  int errors = 0;

  popcount_scale_acc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present a word, wait (bounded) for acceptance, then scramble in_data.
  task automatic send(input logic [15:0] d, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~d;
    in_last  = ~last;
  endtask

  // Send a word and check out_valid on each of the five following edges.
  task automatic run_word(input string tag, input logic [15:0] d, input logic last,
                          input logic [15:0] exp);
    send(d, last);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      check({tag, "_valid"}, out_valid, (k == 5 && last) ? 1 : 0);
    end
    if (last) begin
      check({tag, "_data"}, out_data, exp);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_drop"}, out_valid, 0);
      check({tag, "_ready"}, in_ready, 1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    run_word("zero", 16'h0000, 1'b1, 16'd0);
    run_word("ffff", 16'hFFFF, 1'b1, 16'd512);
    run_word("8421", 16'h8421, 1'b1, 16'd128);
    run_word("0007", 16'h0007, 1'b1, 16'd96);

    run_word("blk_w1", 16'h00FF, 1'b0, 16'd0);
    run_word("blk_w2", 16'h0F0F, 1'b1, 16'd512);

    for (int w = 1; w < 128; w++) run_word("sat_w", 16'hFFFF, 1'b0, 16'd0);
    run_word("sat_end", 16'hFFFF, 1'b1, 16'd65535);
    run_word("after_sat", 16'h0001, 1'b1, 16'd32);

    // back-pressure with stray in_valid pulses
    send(16'hFFFF, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("bp_valid0", out_valid, 1);
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      in_data  = 16'h1234;
      in_last  = 1'b1;
      @(posedge clk);
      #1;
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 512);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_drop", out_valid, 0);
    check("bp_in_ready_after", in_ready, 1);
    run_word("post_bp", 16'h0003, 1'b1, 16'd64);

    // reset mid-LOOK with a partial block already accumulated
    run_word("pre_rst", 16'h00FF, 1'b0, 16'd0);
    send(16'hFFFF, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_ready", in_ready, 1);
    run_word("resend", 16'hFFFF, 1'b1, 16'd512);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
